// File: rtl/regfile_sb.sv
// Register file with per-register busy scoreboard, optional write-to-read forwarding
// and a bulk-clear sequencer that walks every register once.
//
// state | meaning
// IDLE  | normal operation, writes/reserves/clear requests accepted
// CLEAR | zeroing reg[ptr] and busy[ptr], one register per cycle
// DONE  | one-cycle completion pulse, then back to IDLE
module regfile_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2,
    output logic [DATA_W-1:0] rd_data1,
    output logic [DATA_W-1:0] rd_data2,
    output logic              rd_busy1,
    output logic              rd_busy2,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rsv_en,
    input  logic [ADDR_W-1:0] rsv_addr,
    input  logic              clr_req,
    output logic              clr_busy,
    output logic              clr_done
);

    localparam int N = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(N - 1);

    typedef enum logic [1:0] {IDLE, CLEAR, DONE} state_t;

    state_t            state;
    logic [ADDR_W-1:0] ptr;
    logic [DATA_W-1:0] regs [N];
    logic [N-1:0]      busy;

    logic isIdle;
    logic wrHit;
    logic rsvHit;
    logic fwdOk;

    assign isIdle = (state == IDLE);
    assign wrHit  = isIdle && wr_en  && !(ZERO_REG != 0 && wr_addr  == '0);
    assign rsvHit = isIdle && rsv_en && !(ZERO_REG != 0 && rsv_addr == '0);
    assign fwdOk  = (BYPASS != 0) && isIdle && wr_en;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            ptr      <= '0;
            clr_busy <= 1'b0;
            clr_done <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    clr_done <= 1'b0;
                    if (clr_req) begin
                        state    <= CLEAR;
                        ptr      <= '0;
                        clr_busy <= 1'b1;
                    end
                end
                CLEAR: begin
                    ptr <= ptr + 1'b1;
                    if (ptr == LAST_PTR) begin
                        state    <= DONE;
                        clr_done <= 1'b1;
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    clr_busy <= 1'b0;
                    clr_done <= 1'b0;
                end
                default: begin
                    state    <= IDLE;
                    clr_busy <= 1'b0;
                    clr_done <= 1'b0;
                end
            endcase
        end
    end

    // Reserve is applied after the write so a same-address pair leaves busy set.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N; i++) regs[i] <= '0;
            busy <= '0;
        end else if (state == CLEAR) begin
            regs[ptr] <= '0;
            busy[ptr] <= 1'b0;
        end else begin
            if (wrHit) begin
                regs[wr_addr] <= wr_data;
                busy[wr_addr] <= 1'b0;
            end
            if (rsvHit) busy[rsv_addr] <= 1'b1;
        end
    end

    logic [ADDR_W-1:0] rdAddr [2];
    logic [DATA_W-1:0] rdData [2];
    logic [1:0]        rdBusy;

    assign rdAddr[0] = rd_addr1;
    assign rdAddr[1] = rd_addr2;

    always_comb begin
        for (int k = 0; k < 2; k++) begin
            rdData[k] = regs[rdAddr[k]];
            rdBusy[k] = busy[rdAddr[k]];
            if (!rst || (ZERO_REG != 0 && rdAddr[k] == '0)) begin
                rdData[k] = '0;
                rdBusy[k] = 1'b0;
            end else if (fwdOk && wr_addr == rdAddr[k]) begin
                rdData[k] = wr_data;
                rdBusy[k] = 1'b0;
            end
        end
    end

    assign rd_data1 = rdData[0];
    assign rd_data2 = rdData[1];
    assign rd_busy1 = rdBusy[0];
    assign rd_busy2 = rdBusy[1];

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: directed scenarios plus random traffic, all checked against
// an array-based reference model; a second instance has forwarding disabled.
module tb_regfile_sb;

    localparam int N = 32;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  rd_addr1, rd_addr2, wr_addr, rsv_addr;
    logic [31:0] wr_data;
    logic        wr_en, rsv_en, clr_req;

    logic [31:0] aData1, aData2, bData1, bData2;
    logic        aBusy1, aBusy2, bBusy1, bBusy2;
    logic        aClrBusy, aClrDone, bClrBusy, bClrDone;

    regfile_sb dutA (
        .clk(clk), .rst(rst),
        .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .rd_data1(aData1), .rd_data2(aData2),
        .rd_busy1(aBusy1), .rd_busy2(aBusy2),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .clr_req(clr_req),
        .clr_busy(aClrBusy), .clr_done(aClrDone)
    );

    regfile_sb #(.BYPASS(0)) dutB (
        .clk(clk), .rst(rst),
        .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .rd_data1(bData1), .rd_data2(bData2),
        .rd_busy1(bBusy1), .rd_busy2(bBusy2),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .clr_req(clr_req),
        .clr_busy(bClrBusy), .clr_done(bClrDone)
    );

    always #5 clk = ~clk;

    int nCompared = 0;
    int nMismatched = 0;

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        nCompared++;
        if (observed !== expected) begin
            nMismatched++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Reference model: contents, busy flags, and cycles elapsed since a clear was accepted
    // (0 = no clear; 1..N = sweeping register age-1; N+1 = completion cycle).
    logic [31:0] mReg [N];
    bit          mBusy [N];
    int          mAge;
    bit          mInRst;

    function automatic void modelReset();
        for (int i = 0; i < N; i++) begin
            mReg[i]  = '0;
            mBusy[i] = 1'b0;
        end
        mAge = 0;
    endfunction

    function automatic logic [31:0] expData(input logic [4:0] a, input bit fwd);
        if (mInRst || a == 0) return '0;
        if (fwd && mAge == 0 && wr_en && wr_addr == a) return wr_data;
        return mReg[a];
    endfunction

    function automatic logic expBusy(input logic [4:0] a, input bit fwd);
        if (mInRst || a == 0) return 1'b0;
        if (fwd && mAge == 0 && wr_en && wr_addr == a) return 1'b0;
        return mBusy[a];
    endfunction

    function automatic void modelEdge();
        if (mAge == 0) begin
            if (wr_en && wr_addr != 0) begin
                mReg[wr_addr]  = wr_data;
                mBusy[wr_addr] = 1'b0;
            end
            if (rsv_en && rsv_addr != 0) mBusy[rsv_addr] = 1'b1;
            if (clr_req) mAge = 1;
        end else if (mAge <= N) begin
            mReg[mAge-1]  = '0;
            mBusy[mAge-1] = 1'b0;
            mAge++;
        end else begin
            mAge = 0;
        end
    endfunction

    task automatic checkOutputs();
        #1;
        check("a_data1", aData1, expData(rd_addr1, 1'b1));
        check("a_data2", aData2, expData(rd_addr2, 1'b1));
        check("a_busy1", aBusy1, expBusy(rd_addr1, 1'b1));
        check("a_busy2", aBusy2, expBusy(rd_addr2, 1'b1));
        check("b_data1", bData1, expData(rd_addr1, 1'b0));
        check("b_data2", bData2, expData(rd_addr2, 1'b0));
        check("b_busy2", bBusy2, expBusy(rd_addr2, 1'b0));
        check("a_clr_busy", aClrBusy, !mInRst && mAge > 0);
        check("a_clr_done", aClrDone, !mInRst && mAge == N + 1);
        check("b_clr_done", bClrDone, !mInRst && mAge == N + 1);
    endtask

    task automatic step();
        @(posedge clk);
        if (rst) modelEdge();
        #1;
    endtask

    task automatic idleInputs();
        wr_en = 0; rsv_en = 0; clr_req = 0;
    endtask

    int busyCycles, doneCount, doneAt;

    initial begin
        rst = 1'b0; mInRst = 1; modelReset();
        rd_addr1 = 5'd4; rd_addr2 = 5'd9; rsv_addr = 5'd9;
        wr_en = 1; wr_addr = 5'd4; wr_data = 32'hA5A5A5A5; rsv_en = 1; clr_req = 1;
        for (int i = 0; i < 3; i++) begin
            checkOutputs();
            step();
        end
        idleInputs();
        rst = 1'b1; mInRst = 0;
        checkOutputs();
        step();

        // write then read back
        wr_en = 1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF; rd_addr1 = 5'd1;
        checkOutputs(); step();
        wr_en = 0; rd_addr1 = 5'd5;
        checkOutputs();
        check("r5_data", aData1, 32'hDEADBEEF);
        check("r5_busy", aBusy1, 1'b0);
        step();

        // same-cycle forwarding on vs off
        wr_en = 1; wr_addr = 5'd7; wr_data = 32'h12345678; rd_addr2 = 5'd7;
        checkOutputs();
        check("fwd_on", aData2, 32'h12345678);
        check("fwd_off", bData2, 32'h0);
        step(); wr_en = 0;

        // register 0 is hardwired
        wr_en = 1; wr_addr = 5'd0; wr_data = 32'hFFFFFFFF; rsv_en = 1; rsv_addr = 5'd0; rd_addr1 = 5'd0;
        checkOutputs();
        check("r0_fwd_data", aData1, 32'h0);
        step(); idleInputs();
        checkOutputs();
        check("r0_data", aData1, 32'h0);
        check("r0_busy", aBusy1, 1'b0);
        step();

        // reserve / write interplay on r3
        rsv_en = 1; rsv_addr = 5'd3; rd_addr1 = 5'd3;
        checkOutputs(); step(); idleInputs();
        checkOutputs();
        check("r3_rsv_busy", aBusy1, 1'b1);
        rsv_en = 1; wr_en = 1; wr_addr = 5'd3; wr_data = 32'h33;
        checkOutputs(); step(); idleInputs();
        checkOutputs();
        check("r3_both_busy", aBusy1, 1'b1);
        check("r3_both_data", aData1, 32'h33);
        wr_en = 1; wr_data = 32'h44;
        checkOutputs(); step(); idleInputs();
        checkOutputs();
        check("r3_wr_busy", aBusy1, 1'b0);
        check("r3_wr_data", aData1, 32'h44);

        // fill, then bulk clear with a write attempted mid-clear
        for (int i = 1; i < N; i++) begin
            wr_en = 1; wr_addr = 5'(i); wr_data = 32'(i) * 32'h01010101;
            rsv_en = (i % 3 == 0); rsv_addr = 5'(i);
            checkOutputs(); step();
        end
        idleInputs();
        clr_req = 1;
        checkOutputs(); step(); clr_req = 0;
        busyCycles = 0; doneCount = 0; doneAt = -1;
        for (int c = 0; c < 40; c++) begin
            wr_en = (c == 5); wr_addr = 5'd30; wr_data = 32'hBAD0BAD0; rd_addr1 = 5'd30;
            rsv_en = (c == 6); rsv_addr = 5'd31;
            checkOutputs();
            if (aClrBusy) busyCycles++;
            if (aClrDone) begin doneCount++; doneAt = c; end
            step();
            if (c == 33) idleInputs();
        end
        idleInputs();
        check("clr_busy_cycles", busyCycles, N + 1);
        check("clr_done_count", doneCount, 1);
        check("clr_done_at", doneAt, N);
        for (int i = 0; i < N; i++) begin
            rd_addr1 = 5'(i);
            #1;
            check("cleared_data", aData1, 32'h0);
            check("cleared_busy", aBusy1, 1'b0);
        end
        step();

        // reset mid-clear
        wr_en = 1; wr_addr = 5'd20; wr_data = 32'h20202020;
        checkOutputs(); step(); idleInputs();
        clr_req = 1;
        checkOutputs(); step(); clr_req = 0;
        for (int i = 0; i < 10; i++) begin
            checkOutputs(); step();
        end
        rd_addr1 = 5'd20;
        rst = 1'b0; mInRst = 1; modelReset();
        #1;
        check("rst_clr_busy", aClrBusy, 1'b0);
        check("rst_data", aData1, 32'h0);
        for (int i = 0; i < 2; i++) begin
            checkOutputs(); step();
        end
        rst = 1'b1; mInRst = 0;
        doneCount = 0;
        for (int i = 0; i < 40; i++) begin
            checkOutputs();
            if (aClrDone) doneCount++;
            step();
        end
        check("rst_no_done", doneCount, 0);
        rd_addr1 = 5'd20;
        checkOutputs();
        check("rst_r20", aData1, 32'h0);

        // random traffic
        for (int i = 0; i < 800; i++) begin
            wr_en    = ($urandom_range(0, 1) == 1);
            rsv_en   = ($urandom_range(0, 2) == 0);
            clr_req  = ($urandom_range(0, 60) == 0);
            wr_addr  = 5'($urandom_range(0, 7));
            rsv_addr = 5'($urandom_range(0, 7));
            rd_addr1 = 5'($urandom_range(0, 7));
            rd_addr2 = ($urandom_range(0, 3) == 0) ? 5'($urandom) : wr_addr;
            wr_data  = $urandom;
            checkOutputs();
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 SHALL expose parameter DATA_W, default 32, register data width in bits.
REQ-002 SHALL expose parameter ADDR_W, default 5, register address width; register count N = 2**ADDR_W.
REQ-003 SHALL expose parameter ZERO_REG, default 1, nonzero = register 0 hardwired to zero.
REQ-004 SHALL expose parameter BYPASS, default 1, nonzero = same-cycle write-to-read forwarding.
REQ-005 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-006 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have ports rd_addr1, rd_addr2  input  ADDR_W  read port addresses.
REQ-008 SHALL have ports rd_data1, rd_data2  output  DATA_W  read data, combinational.
REQ-009 SHALL have ports rd_busy1, rd_busy2  output  1  scoreboard busy bit of addressed register.
REQ-010 SHALL have ports wr_en  input  1, wr_addr  input  ADDR_W, wr_data  input  DATA_W: write port.
REQ-011 SHALL have ports rsv_en  input  1, rsv_addr  input  ADDR_W: reserve (mark busy) port.
REQ-012 SHALL have port clr_req  input  1  request bulk clear.
REQ-013 SHALL have ports clr_busy  output  1  clear in progress; clr_done  output  1  one-cycle completion pulse.

Function
REQ-014 SHALL hold N registers of DATA_W bits plus N busy bits.
REQ-015 SHALL write wr_data to reg[wr_addr] and clear busy[wr_addr] at clk edge when wr_en=1 and FSM in IDLE.
REQ-016 SHALL set busy[rsv_addr] at clk edge when rsv_en=1 and FSM in IDLE.
REQ-017 SHALL, on rsv and wr to same address in one cycle, store wr_data and leave busy=1 (reserve wins).
REQ-018 SHALL drive rd_dataK = reg[rd_addrK] combinationally, 0-cycle latency.
REQ-019 SHALL, with BYPASS!=0, FSM IDLE, wr_en=1, wr_addr==rd_addrK: drive rd_dataK=wr_data and rd_busyK=0.
REQ-020 SHALL, with ZERO_REG!=0, read register 0 as all-zero, ignore writes/reserves to it, report busy 0, never bypass it.
REQ-021 SHALL implement clear FSM states IDLE, CLEAR, DONE.
REQ-022 SHALL move IDLE->CLEAR on clr_req=1, loading pointer ptr=0.
REQ-023 SHALL in CLEAR, each cycle, zero reg[ptr] and busy[ptr], increment ptr; at ptr==N-1 go to DONE.
REQ-024 SHALL go DONE->IDLE unconditionally after one cycle; clr_done=1 only in DONE.
REQ-025 SHALL assert clr_busy=1 in CLEAR and DONE, 0 in IDLE; clear takes exactly N cycles in CLEAR.
REQ-026 SHALL ignore wr_en, rsv_en and clr_req while clr_busy=1; no bypass while clr_busy=1.
REQ-027 SHALL return current stored contents to reads during CLEAR (partially cleared state visible).
REQ-028 SHALL wrap ptr modulo N; ptr width ADDR_W, no overflow bit.
REQ-029 SHALL accept clr_req together with wr_en/rsv_en in IDLE: write/reserve applied that edge, then clear overwrites.

Reset
REQ-030 SHALL on rst=0, immediately and asynchronously, zero all registers and busy bits, FSM=IDLE, ptr=0.
REQ-031 SHALL drive clr_busy=0, clr_done=0, rd_busy1/2=0, rd_data1/2=0 while rst=0.
REQ-032 SHALL abort an in-progress clear on rst=0 with no clr_done pulse.
REQ-033 SHALL resume normal operation on first clk edge after rst returns to 1.

Verification
REQ-034 SHALL test: write 0xDEADBEEF to r5, read r5 next cycle -> rd_data1=0xDEADBEEF, rd_busy1=0.
REQ-035 SHALL test: wr_en r7=0x12345678 with rd_addr2=7 same cycle, BYPASS=1 -> rd_data2=0x12345678; BYPASS=0 -> old value.
REQ-036 SHALL test: write 0xFFFFFFFF to r0 (ZERO_REG=1), reserve r0 -> rd_data=0, rd_busy=0.
REQ-037 SHALL test: reserve r3 -> rd_busy=1; rsv+wr r3 same cycle -> busy stays 1, data stored; wr r3 alone -> busy 0.
REQ-038 SHALL test: fill regs, pulse clr_req -> clr_busy=1 for N+1 cycles, clr_done one cycle after N CLEAR cycles, all regs 0, mid-clear write ignored.
REQ-039 SHALL test: rst=0 mid-clear at ptr=10 -> all regs 0, clr_busy=0 asynchronously, no clr_done.
